// File: rtl/mips_pkg.sv
// Shared types for the multi-cycle MIPS core: HI/LO multiply/divide opcodes,
// sequencer states and iteration constants.
package mips_pkg;

    localparam int unsigned MULDIV_ITER  = 32;
    localparam int unsigned MULDIV_CNT_W = $clog2(MULDIV_ITER);

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Multiply/divide datapath: shift-add multiplier, restoring divider and the
// sign-fixup negators. Sequenced by load/step/fixup from muldiv_sequencer.
// Optional feature: MULDIV_EARLY_TERM_EN (early multiply exit; the product is
// realigned by the number of skipped iterations during fixup).
module muldiv_iter
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic                    step,
    input  logic                    fixup,
    input  logic                    is_div,
    input  logic                    is_signed,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
`ifdef MULDIV_EARLY_TERM_EN
    input  logic [MULDIV_CNT_W-1:0] count,
    output logic                    mul_last_c,
`endif
    output logic [WIDTH-1:0]        res_hi_c,
    output logic [WIDTH-1:0]        res_lo_c
);

    localparam int unsigned AW = 2 * WIDTH;

    logic [AW-1:0]    acc;       // multiply: product; divide: {remainder, quotient}
    logic [WIDTH-1:0] opnd;      // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] aux;       // multiply: remaining multiplier; divide: raw dividend
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic             rem_ge;
    logic [AW-1:0]    prod;
    logic [AW-1:0]    prod_fix;

    // Operand magnitudes and the per-iteration add / compare-subtract
    always_comb begin
        a_mag   = (is_signed && a[WIDTH-1]) ? WIDTH'(-a) : a;
        b_mag   = (is_signed && b[WIDTH-1]) ? WIDTH'(-b) : b;
        mul_sum = {1'b0, acc[AW-1:WIDTH]} + (aux[0] ? {1'b0, opnd} : '0);
        rem_sh  = acc[AW-1:WIDTH-1];
        rem_sub = rem_sh - {1'b0, opnd};
        rem_ge  = (rem_sh >= {1'b0, opnd});
`ifdef MULDIV_EARLY_TERM_EN
        mul_last_c = !is_div && (aux[WIDTH-1:1] == '0);
`endif
    end

    // Working registers: load operands, iterate, clear after writeback
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            opnd     <= '0;
            aux      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (load) begin
            acc      <= is_div ? {WIDTH'(0), a_mag} : '0;
            opnd     <= is_div ? b_mag : a_mag;
            aux      <= is_div ? a : b_mag;
            neg_q    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r    <= is_signed && a[WIDTH-1];
            div_zero <= is_div && (b == '0);
        end else if (step) begin
            if (is_div) begin
                acc <= rem_ge ? {rem_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                              : {rem_sh[WIDTH-1:0],  acc[WIDTH-2:0], 1'b0};
            end else begin
                acc <= {mul_sum, acc[WIDTH-1:1]};
                aux <= aux >> 1;
            end
        end else if (fixup) begin
            acc  <= '0;
            opnd <= '0;
            aux  <= '0;
        end
    end

    // Sign fixup and HI/LO selection, consumed during the FIXUP cycle
    always_comb begin
`ifdef MULDIV_EARLY_TERM_EN
        prod = acc >> ((MULDIV_CNT_W + 1)'(MULDIV_ITER - 1) - (MULDIV_CNT_W + 1)'(count));
`else
        prod = acc;
`endif
        prod_fix = neg_q ? AW'(-prod) : prod;
        res_hi_c = prod_fix[AW-1:WIDTH];
        res_lo_c = prod_fix[WIDTH-1:0];
        if (div_zero) begin
            res_hi_c = aux;
            res_lo_c = '1;
        end else if (is_div) begin
            res_hi_c = neg_r ? WIDTH'(-acc[AW-1:WIDTH]) : acc[AW-1:WIDTH];
            res_lo_c = neg_q ? WIDTH'(-acc[WIDTH-1:0])  : acc[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: accepts one op in IDLE, iterates in
// muldiv_iter, writes HI/LO in FIXUP and pulses done. Handles MTHI/MTLO.
// Optional feature: MULDIV_EARLY_TERM_EN (multiply leaves CALC once the
// remaining multiplier is zero).
module muldiv_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_t           state;
    logic [MULDIV_CNT_W-1:0] count;
    logic                    div_q;

    logic             op_long_c;
    logic             op_div_c;
    logic             op_signed_c;
    logic             load;
    logic             step;
    logic             fixup;
    logic             is_div;
    logic             calc_exit;
    logic [WIDTH-1:0] res_hi_c;
    logic [WIDTH-1:0] res_lo_c;
`ifdef MULDIV_EARLY_TERM_EN
    logic             mul_last_c;
`endif

    // Opcode decode and datapath controls
    always_comb begin
        op_div_c    = (op == MD_DIV) || (op == MD_DIVU);
        op_long_c   = (op == MD_MULT) || (op == MD_MULTU) || op_div_c;
        op_signed_c = (op == MD_MULT) || (op == MD_DIV);
        load        = (state == ST_IDLE) && start && op_long_c;
        step        = (state == ST_CALC);
        fixup       = (state == ST_FIXUP);
        is_div      = load ? op_div_c : div_q;
        calc_exit   = (count == MULDIV_CNT_W'(MULDIV_ITER - 1));
`ifdef MULDIV_EARLY_TERM_EN
        calc_exit   = calc_exit || mul_last_c;
`endif
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .step       (step),
        .fixup      (fixup),
        .is_div     (is_div),
        .is_signed  (op_signed_c),
        .a          (a),
        .b          (b),
`ifdef MULDIV_EARLY_TERM_EN
        .count      (count),
        .mul_last_c (mul_last_c),
`endif
        .res_hi_c   (res_hi_c),
        .res_lo_c   (res_lo_c)
    );

    // Sequencer FSM with registered busy/done and HI/LO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            count <= '0;
            div_q <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        div_q <= op_div_c;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= (op_div_c && (b == '0)) ? ST_FIXUP : ST_CALC;
                    end else if (start && (op == MD_MTHI)) begin
                        hi <= a;
                    end else if (start && (op == MD_MTLO)) begin
                        lo <= a;
                    end
                end
                ST_CALC: begin
                    if (calc_exit) begin
                        state <= ST_FIXUP;
                    end else begin
                        count <= count + MULDIV_CNT_W'(1);
                    end
                end
                ST_FIXUP: begin
                    hi    <= res_hi_c;
                    lo    <= res_lo_c;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
